// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_pkg
// Brief    : Shared constants for the d16 instruction sequencer: stage
//            encodings, stage width and the FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

  localparam int SEQ_STAGE_W = 4;

  // Stage encodings, also visible on the debug stage port
  localparam logic [SEQ_STAGE_W-1:0] SEQ_IDLE     = 4'd0;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_FETCH    = 4'd1;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_DECODE   = 4'd2;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_DISPATCH = 4'd3;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_IMM      = 4'd4;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_REGREAD  = 4'd5;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_ALU      = 4'd6;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_MEM      = 4'd7;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_WB       = 4'd8;
  localparam logic [SEQ_STAGE_W-1:0] SEQ_FAULT    = 4'd15;

  typedef enum logic [SEQ_STAGE_W-1:0] {
    ST_IDLE     = SEQ_IDLE,
    ST_FETCH    = SEQ_FETCH,
    ST_DECODE   = SEQ_DECODE,
    ST_DISPATCH = SEQ_DISPATCH,
    ST_IMM      = SEQ_IMM,
    ST_REGREAD  = SEQ_REGREAD,
    ST_ALU      = SEQ_ALU,
    ST_MEM      = SEQ_MEM,
    ST_WB       = SEQ_WB,
    ST_FAULT    = SEQ_FAULT
  } seq_state_t;

  // States that hold mem_req high and wait for mem_ready
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_IMM) || (s == ST_MEM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Brief    : Counts cycles a memory request has waited for mem_ready and
//            flags a timeout when the count reaches MAX_WAIT with no
//            acknowledge. MAX_WAIT = 0 disables the timeout.
// Revision : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_count;

  // Wait counter: restart on entry to a wait state or on acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || mem_ready) begin
      r_count <= '0;
    end else if (active) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // An acknowledge arriving on the limit cycle takes priority over the fault
  always_comb begin
    timeout = (MAX_WAIT != 0) && active && !mem_ready && (r_count == C_LIMIT);
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Multi-cycle control FSM for the d16 core. Steps each instruction
//            through fetch, decode, dispatch, optional immediate fetch,
//            register read, ALU, optional memory access and writeback.
//            Optional macro SEQ_SINGLE_STEP_EN adds a step input that lets a
//            halted sequencer run exactly one instruction per pass.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   step,
`endif
  input  logic                   halt_req,
  input  logic                   mem_ready,
  input  logic                   dec_next_word,
  input  logic                   dec_en_mem,
  output logic                   en_fetch,
  output logic                   en_decode,
  output logic                   en_imm_fetch,
  output logic                   en_regread,
  output logic                   en_alu,
  output logic                   en_memstage,
  output logic                   en_writeback,
  output logic                   mem_req,
  output logic                   pc_inc,
  output logic [SEQ_STAGE_W-1:0] stage,
  output logic                   halted,
  output logic                   bus_error
);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic       w_timeout;
  logic       w_wait_active;
  logic       w_wait_clear;
  logic       w_leave_idle;

  // Wait-state bookkeeping for the timer: counting while waiting, fresh start on entry
  always_comb begin
    w_wait_active = is_wait_state(r_state);
    w_wait_clear  = is_wait_state(w_state_next) && (w_state_next != r_state);
  end

  seq_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_wait_clear),
    .active    (w_wait_active),
    .mem_ready (mem_ready),
    .timeout   (w_timeout)
  );

  // IDLE exit condition; a step pulse overrides a pending halt when enabled
  always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
    w_leave_idle = !halt_req || step;
`else
    w_leave_idle = !halt_req;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore strobe decode; pc_inc is the only Mealy output
  always_comb begin
    w_state_next = r_state;
    en_fetch     = 1'b0;
    en_decode    = 1'b0;
    en_imm_fetch = 1'b0;
    en_regread   = 1'b0;
    en_alu       = 1'b0;
    en_memstage  = 1'b0;
    en_writeback = 1'b0;
    mem_req      = 1'b0;
    pc_inc       = 1'b0;
    halted       = 1'b0;
    bus_error    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        halted = 1'b1;
        if (w_leave_idle) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        en_fetch = 1'b1;
        pc_inc   = mem_ready;
        if (mem_ready)      w_state_next = ST_DECODE;
        else if (w_timeout) w_state_next = ST_FAULT;
      end
      ST_DECODE: begin
        en_decode    = 1'b1;
        w_state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        w_state_next = dec_next_word ? ST_IMM : ST_REGREAD;
      end
      ST_IMM: begin
        mem_req      = 1'b1;
        en_imm_fetch = 1'b1;
        pc_inc       = mem_ready;
        if (mem_ready)      w_state_next = ST_REGREAD;
        else if (w_timeout) w_state_next = ST_FAULT;
      end
      ST_REGREAD: begin
        en_regread   = 1'b1;
        w_state_next = ST_ALU;
      end
      ST_ALU: begin
        en_alu       = 1'b1;
        w_state_next = dec_en_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req     = 1'b1;
        en_memstage = 1'b1;
        if (mem_ready)      w_state_next = ST_WB;
        else if (w_timeout) w_state_next = ST_FAULT;
      end
      ST_WB: begin
        en_writeback = 1'b1;
        w_state_next = halt_req ? ST_IDLE : ST_FETCH;
      end
      ST_FAULT: begin
        bus_error = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Debug view of the current stage
  always_comb begin
    stage = r_state;
  end

endmodule
`default_nettype wire
